// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width and Gray/binary conversions.
// Conversions work on MaxPtrW bits; callers zero-extend narrower pointers and drop the upper bits.
package fifo_pkg;

  localparam int unsigned DefaultAddrLines = 8;
  localparam int unsigned MaxPtrW          = 32;

  function automatic logic [MaxPtrW-1:0] bin2gray(input logic [MaxPtrW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // XOR prefix from the MSB down.
  function automatic logic [MaxPtrW-1:0] gray2bin(input logic [MaxPtrW-1:0] g);
    logic [MaxPtrW-1:0] b;
    b[MaxPtrW-1] = g[MaxPtrW-1];
    for (int i = MaxPtrW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchroniser bringing a read-domain bus into the write clock domain.
module sync_r2w #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] wq1;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wq1 <= '0;
      q   <= '0;
    end else begin
      wq1 <= d;
      q   <= wq1;
    end
  end

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer and status logic of the async FIFO: binary/Gray write pointers,
// synchronised read pointer, and registered full, almost-full, fill count and sticky overflow.
module wptr_full import fifo_pkg::*; #(
  parameter int unsigned ADDR_LINES  = DefaultAddrLines,
  parameter int unsigned AFULL_LEVEL = 192
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [ADDR_LINES:0]   rptr,
  input  logic                  ovf_clr,
  output logic [ADDR_LINES-1:0] waddr,
  output logic [ADDR_LINES:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_LINES:0]   wcount,
  output logic                  woverflow
);

  localparam int unsigned PtrW = ADDR_LINES + 1;

  logic [PtrW-1:0]         wbin;
  logic [PtrW-1:0]         wbinnext;
  logic [PtrW-1:0]         wgraynext;
  logic [PtrW-1:0]         wq2_rptr;
  logic [PtrW-1:0]         wq2_rbin;
  logic [PtrW-1:0]         wcount_next;
  logic [MaxPtrW-PtrW-1:0] gray_unused;
  logic [MaxPtrW-PtrW-1:0] rbin_unused;
  logic                    accept;
  logic                    wfull_val;
  logic                    afull_val;

  sync_r2w #(
    .WIDTH (PtrW)
  ) u_sync_r2w (
    .wclk (wclk),
    .wrst (wrst),
    .d    (rptr),
    .q    (wq2_rptr)
  );

  always_comb begin
    accept                   = winc & ~wfull;
    wbinnext                 = wbin + PtrW'(accept);
    {gray_unused, wgraynext} = bin2gray(MaxPtrW'(wbinnext));
    {rbin_unused, wq2_rbin}  = gray2bin(MaxPtrW'(wq2_rptr));
    // Full when the write pointer leads the read pointer by exactly one lap.
    wfull_val   = (wgraynext == {~wq2_rptr[PtrW-1:PtrW-2], wq2_rptr[PtrW-3:0]});
    wcount_next = wbinnext - wq2_rbin;
    afull_val   = (wcount_next >= PtrW'(AFULL_LEVEL));
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= wfull_val;
      walmost_full <= afull_val;
      wcount       <= wcount_next;
      // A rejected write outranks a simultaneous clear.
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end else if (ovf_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

  assign waddr = wbin[ADDR_LINES-1:0];

endmodule

// File: tb/tb_wptr_full.sv
// Bench for wptr_full (ADDR_LINES=4, AFULL_LEVEL=12): a behavioural model pushes expected
// outputs as each cycle is driven; every scenario task pops and compares after the edge.
module tb_wptr_full;

  localparam int unsigned AL    = 4;
  localparam int unsigned AFULL = 12;

  typedef struct packed {
    logic [3:0] addr;
    logic [4:0] ptr;
    logic       full;
    logic       af;
    logic [4:0] cnt;
    logic       ovf;
  } exp_t;

  logic       wclk;
  logic       wrst;
  logic       winc;
  logic [4:0] rptr;
  logic       ovf_clr;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wcount;
  logic       woverflow;

  int errors = 0;
  int checks = 0;

  exp_t sb[$];

  // Model state: binary write pointer, read pointer pipeline, registered status.
  logic [4:0] m_wbin, m_q1, m_q2, m_cnt;
  logic       m_full, m_af, m_ovf, m_acc;
  logic [4:0] rd_bin;

  wptr_full #(
    .ADDR_LINES  (AL),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .rptr         (rptr),
    .ovf_clr      (ovf_clr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .woverflow    (woverflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] from_gray(input logic [4:0] g);
    logic [4:0] b;
    b = g;
    for (int s = 1; s < 5; s = s * 2) b = b ^ (b >> s);
    return b;
  endfunction

  function automatic exp_t observe();
    return exp_t'({waddr, wptr, wfull, walmost_full, wcount, woverflow});
  endfunction

  function automatic string fmt(input exp_t v);
    return $sformatf("addr=%0d ptr=%b full=%b af=%b cnt=%0d ovf=%b",
                     v.addr, v.ptr, v.full, v.af, v.cnt, v.ovf);
  endfunction

  // Drive one cycle, advance the model, push its expected outputs, sample #1 after the edge.
  task automatic cyc(input logic rst, input logic inc, input logic [4:0] rp, input logic clr);
    logic [4:0] nb;
    exp_t       e;
    @(negedge wclk);
    wrst    = rst;
    winc    = inc;
    rptr    = rp;
    ovf_clr = clr;
    if (rst) begin
      m_wbin = '0; m_q1 = '0; m_q2 = '0; m_cnt = '0;
      m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0; m_acc = 1'b0;
    end else begin
      m_acc  = inc && !m_full;
      nb     = m_wbin + {4'b0, m_acc};
      m_ovf  = (inc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_cnt  = nb - from_gray(m_q2);
      m_full = (m_cnt == 5'd16);
      m_af   = (m_cnt >= 5'(AFULL));
      m_wbin = nb;
      m_q2   = m_q1;
      m_q1   = rp;
    end
    e = '{addr: m_wbin[3:0], ptr: to_gray(m_wbin), full: m_full, af: m_af, cnt: m_cnt,
          ovf: m_ovf};
    sb.push_back(e);
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    exp_t got, e;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 5'd0, 1'b0);
      got = observe(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL reset[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      end
      checks++;
      if (got !== exp_t'(0)) begin
        errors++; $display("FAIL reset_zero[%0d]: got %s, expected all zero", i, fmt(got));
      end
    end
  endtask

  task automatic test_fill();
    exp_t got, e;
    logic exp_af;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 5'd0, 1'b0);
      got = observe(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL fill[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      end
      exp_af = (i + 1 >= 12);
      checks++;
      if (wcount !== 5'(i + 1) || walmost_full !== exp_af) begin
        errors++;
        $display("FAIL fill_count[%0d]: got cnt=%0d af=%b, expected cnt=%0d af=%b",
                 i, wcount, walmost_full, i + 1, exp_af);
      end
    end
    checks++;
    if (wfull !== 1'b1 || wptr !== 5'b11000 || waddr !== 4'd0) begin
      errors++;
      $display("FAIL fill_full: got full=%b ptr=%b addr=%0d, expected full=1 ptr=11000 addr=0",
               wfull, wptr, waddr);
    end
  endtask

  task automatic test_overflow();
    exp_t got, e;
    logic [2:0] inc_seq = 3'b110;
    logic [2:0] clr_seq = 3'b011;
    logic [2:0] ovf_exp = 3'b110;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, inc_seq[2-i], 5'd0, clr_seq[2-i]);
      got = observe(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL overflow[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      end
      checks++;
      if (woverflow !== ovf_exp[2-i] || waddr !== 4'd0 || wptr !== 5'b11000) begin
        errors++;
        $display("FAIL overflow_flag[%0d]: got ovf=%b addr=%0d ptr=%b, expected ovf=%b addr=0 ptr=11000",
                 i, woverflow, waddr, wptr, ovf_exp[2-i]);
      end
    end
  endtask

  task automatic test_drain();
    exp_t got, e;
    logic       exp_full;
    logic [4:0] exp_cnt;
    rd_bin = 5'd1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, to_gray(rd_bin), 1'b0);
      got = observe(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL drain[%0d]: got %s, expected %s", k, fmt(got), fmt(e));
      end
      exp_full = (k < 2);
      exp_cnt  = (k < 2) ? 5'd16 : 5'd15;
      checks++;
      if (wfull !== exp_full || wcount !== exp_cnt) begin
        errors++;
        $display("FAIL drain_edge[%0d]: got full=%b cnt=%0d, expected full=%b cnt=%0d",
                 k, wfull, wcount, exp_full, exp_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t       got, e;
    logic [4:0] prev;
    int         wraps = 0;
    for (int i = 0; i < 1000 && wraps < 2; i++) begin
      if ($urandom_range(0, 1) == 1 && rd_bin != m_wbin) rd_bin = rd_bin + 5'd1;
      prev = wptr;
      cyc(1'b0, ($urandom_range(0, 3) != 0), to_gray(rd_bin), 1'b0);
      if (m_acc && m_wbin == 5'd0) wraps++;
      got = observe(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL wrap[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      end
      checks++;
      if ($countones(prev ^ wptr) != (m_acc ? 1 : 0)) begin
        errors++;
        $display("FAIL wrap_gray[%0d]: got ptr %b -> %b, expected %0d bit change",
                 i, prev, wptr, m_acc ? 1 : 0);
      end
    end
    checks++;
    if (wraps < 2) begin
      errors++; $display("FAIL wrap_count: got %0d wraps, expected 2", wraps);
    end
  endtask

  task automatic test_midreset();
    exp_t got, e;
    rd_bin = m_wbin;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, (i >= 3), to_gray(rd_bin), 1'b1);
      got = observe(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL pre_reset[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      end
    end
    checks++;
    if (wcount !== 5'd9) begin
      errors++; $display("FAIL pre_reset_count: got %0d, expected 9", wcount);
    end
    rd_bin = 5'd0;
    cyc(1'b1, 1'b1, 5'd0, 1'b0);
    got = observe(); e = sb.pop_front(); checks++;
    if (got !== e) begin
      errors++; $display("FAIL midreset: got %s, expected %s", fmt(got), fmt(e));
    end
    checks++;
    if (wcount !== 5'd0 || wfull !== 1'b0 || waddr !== 4'd0) begin
      errors++;
      $display("FAIL midreset_zero: got cnt=%0d full=%b addr=%0d, expected 0 0 0",
               wcount, wfull, waddr);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 5'd0, 1'b0);
      got = observe(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL resume[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      end
      checks++;
      if (waddr !== 4'(i + 1)) begin
        errors++; $display("FAIL resume_addr[%0d]: got %0d, expected %0d", i, waddr, i + 1);
      end
    end
  endtask

  initial begin
    wrst    = 1'b1;
    winc    = 1'b0;
    rptr    = '0;
    ovf_clr = 1'b0;
    rd_bin  = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-side pointer and status logic for the team's asynchronous FIFO. It is the counterpart of the read-side pointer/empty block and sits in the write clock domain beside the dual-port memory. It keeps the binary write address and the Gray-coded write pointer, and it synchronises the read domain's Gray pointer into the write clock. From those it produces registered full, almost-full, fill-count and sticky overflow status.

## Interface
Parameters:
- ADDR_LINES, 8, memory address width; FIFO depth is 2^ADDR_LINES, pointers are ADDR_LINES+1 bits
- AFULL_LEVEL, 192, fill count at or above which walmost_full asserts; legal range 1..2^ADDR_LINES

Ports:
- wclk  input  1  write clock; the only clock
- wrst  input  1  reset, synchronous, active-high
- winc  input  1  write request; accepted only when wfull=0
- rptr  input  ADDR_LINES+1  Gray read pointer from the read domain, asynchronous to wclk
- ovf_clr  input  1  clears woverflow
- waddr  output  ADDR_LINES  memory write address, wbin[ADDR_LINES-1:0]
- wptr  output  ADDR_LINES+1  registered Gray write pointer, sent to the read domain
- wfull  output  1  registered full flag
- walmost_full  output  1  registered, fill count >= AFULL_LEVEL
- wcount  output  ADDR_LINES+1  registered fill count as seen from the write side, 0..2^ADDR_LINES
- woverflow  output  1  sticky flag, a write was attempted while full

## Operation
- Accept condition: accept = winc & ~wfull. Derived values:
  - wbinnext = wbin + accept
  - wgraynext = (wbinnext>>1) ^ wbinnext
- Pointer registers: wbin and wptr load wbinnext and wgraynext every wclk edge.
- Read-pointer synchroniser: two flops, rptr -> wq1_rptr -> wq2_rptr.
- Full detection: wfull_val = (wgraynext == {~wq2_rptr[ADDR_LINES:ADDR_LINES-1], wq2_rptr[ADDR_LINES-2:0]}), i.e. the two MSBs inverted and the rest equal. wfull registers wfull_val.
- Fill count: wq2_rbin = Gray-to-binary of wq2_rptr, combinational XOR prefix from the MSB down.
  - wcount_next = (wbinnext - wq2_rbin) mod 2^(ADDR_LINES+1)
  - Subtraction is done at ADDR_LINES+1 bits, so pointer wrap needs no special case.
  - wcount and walmost_full (wcount_next >= AFULL_LEVEL) register together.
- Overflow:
  - winc & wfull sets woverflow on the next edge; the write is dropped and wbin is unchanged.
  - ovf_clr clears woverflow.
  - Simultaneous set and clear: set wins.
- Pessimism: wcount, wfull and walmost_full are conservative, since the read pointer is stale by the synchroniser delay. They never under-report occupancy.
- Reset, on wrst=1 at an edge, regardless of winc:
  - wbin, wptr, wq1_rptr, wq2_rptr, wcount are 0
  - wfull, walmost_full, woverflow are 0
  - waddr is 0
- Reset mid-operation discards all contents. The read side must be reset in the same window; a one-sided reset is unsupported.

## Timing
- Write effect: a write accepted at edge N updates waddr, wptr, wcount and walmost_full at edge N. wfull reflects that write at edge N as well.
- Writes until full: from empty, exactly 2^ADDR_LINES back-to-back accepted writes assert wfull. It rises on the edge of the last accepted write, so the next winc is rejected.
- Read-side latency: a read-side rptr change reaches wfull, wcount and walmost_full after 3 wclk edges (2 synchroniser edges plus 1 status register).
- Throughput: one write per cycle when not full; no bubbles.
- Wrap: wbin wraps from 2^(ADDR_LINES+1)-1 to 0 with no glitch. Successive wptr values differ in exactly one bit.

## Structure
- Shared package fifo_pkg holds the ADDR_LINES default, function gray2bin and function bin2gray. The read-side block reuses them.
- One sub-module, sync_r2w: a parameterised 2-flop synchroniser on wclk with sync reset wrst, instantiated for rptr.

## Test plan
Bench settings: ADDR_LINES=4, AFULL_LEVEL=12.
- Reset: hold wrst=1 with winc=1 for 3 cycles -> all outputs 0; wptr stays 0.
- Fill from empty: rptr held 0, winc=1 for 16 cycles -> after each accepted write, wcount steps 1..16. walmost_full is 1 once wcount=12. wfull=1 after write 16 (wptr=5'b11000) and waddr returns to 0.
- Overflow: while full, pulse winc for 1 cycle -> wbin unchanged and woverflow=1. Assert ovf_clr together with another winc -> woverflow stays 1. Assert ovf_clr alone -> woverflow=0.
- Drain visibility: while full, change rptr to Gray(1)=5'b00001 -> wfull=0 and wcount=15 exactly 3 edges later, not earlier.
- Wrap: interleave writes and rptr updates to cycle wbin through 31->0 twice. Check that wptr changes in one bit per write and that wcount matches the reference model (writes - reads synced 2 cycles late) every cycle.
- Mid-operation reset: with wcount=9, assert wrst for 1 cycle -> next edge wcount=0, wfull=0, waddr=0. Writing then resumes from address 0.
